rrat_retire_map: RTL and testbench
==================================

# rrat_retire_map

Parametrised retirement register alias table for the N-way superscalar OoO core. It holds the committed architectural-to-physical register map and accepts up to SCALAR in-order retirements per cycle, with the youngest write winning on same-cycle conflicts. It returns each overwritten physical tag to the free list one cycle later and signals rollback so the front-end RAT can reload the committed map. It sits between the ROB retire stage, the free list, and the RAT.

## Interface
- SCALAR, 2, retire ways per cycle; way 0 is oldest.
- NUM_ARCH, 32, architectural registers; entry 0 is hard-wired.
- NUM_PREG, 64, physical registers; must be at least NUM_ARCH.
- ARCH_IDX_WIDTH, $clog2(NUM_ARCH), architectural index width.
- PREG_IDX_WIDTH, $clog2(NUM_PREG), physical tag width.
- COUNT_WIDTH, 32, retire counter width.
- clock  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high.
- retire_packet  in  SCALAR x {valid, arch[ARCH_IDX_WIDTH], preg[PREG_IDX_WIDTH]}  retirements, in program order by way index.
- rollback_en  in  1  mispredict or exception rollback request (level).
- map_out  out  NUM_ARCH x PREG_IDX_WIDTH  committed map (registered state).
- free_packet  out  SCALAR x {valid, preg[PREG_IDX_WIDTH]}  tags released to the free list (registered).
- rollback_valid  out  1  map_out is the restore image this cycle.
- retire_count  out  COUNT_WIDTH  total accepted retirements (registered).

## Operation
- Reset (asynchronous, takes effect immediately, including mid-operation):
  - map_out[i] = i for every i (identity map).
  - All free_packet.valid = 0.
  - rollback_valid = 0.
  - retire_count = 0.
- Retire chain, evaluated in way order 0..SCALAR-1 against a working copy of the map:
  - Way k is accepted when valid = 1 and arch != 0.
  - An accepted way k reports old = working[arch], then sets working[arch] = preg.
  - The working copy seen by way k already includes the effects of ways 0..k-1.
- Same-arch conflict: when ways j < k target the same arch, way k frees way j's new preg and the final map holds way k's preg.
- Writes to arch 0 are ignored: no map change, no free, not counted.
- Next state:
  - map_out takes the working map after the last way.
  - free_packet[k] = {accepted_k, old_k}; valid is 0 for ways that were not accepted.
  - retire_count increments by the number of accepted ways and wraps modulo 2^COUNT_WIDTH.
- Rollback:
  - rollback_en = 1 in cycle t gives rollback_valid = 1 in cycle t+1.
  - In cycle t+1, map_out holds the map including every retirement accepted in cycle t (retire-then-rollback ordering).
  - Rollback never modifies the map.
  - Holding rollback_en for N cycles gives rollback_valid high for N cycles, delayed by one.
- No legality checks in RTL. A preg already mapped elsewhere, or preg equal to the current mapping, is processed as given; the bench flags these with assertions.

## Timing
- Retire to map_out update: 1 cycle.
- Retire to free_packet: 1 cycle.
- free_packet.valid is a single-cycle pulse per accepted way; the free list must accept SCALAR tags every cycle (no backpressure).
- rollback_en to rollback_valid: 1 cycle.
- All outputs come directly from flops; there are no combinational input-to-output paths.
- Simultaneous retire and rollback in one cycle: both take effect, and rollback_valid then shows the post-retire map.

## Structure
- Shared package rrat_pkg holds:
  - Constants NUM_ARCH, NUM_PREG, and the derived index widths.
  - typedef RRAT_RETIRE_INPACKET {valid, arch, preg}.
  - typedef RRAT_FREE_OUTPACKET {valid, preg}.
- One sub-module, rrat_retire_slice: combinational single-way update (map in, packet in -> map out, free packet out), instantiated SCALAR times in a chain.
- The top level owns the map flops, the free_packet flops, the rollback flop, and the counter.

## Test plan
- Reset, then idle -> map_out[i] = i; all free valid = 0; retire_count = 0; rollback_valid = 0.
- Way0 {1, arch 1, preg 40}, way1 {1, arch 2, preg 41} -> next cycle map[1] = 40, map[2] = 41; free = {1, 1}, {1, 2}; retire_count = 2.
- Way0 {1, arch 5, preg 50}, way1 {1, arch 5, preg 51} -> map[5] = 51; free[0] = 5, free[1] = 50; retire_count += 2.
- Way0 {1, arch 0, preg 60}, way1 valid = 0 -> map[0] stays 0; no free valid; count unchanged.
- rollback_en = 1 in the same cycle as way0 {1, arch 3, preg 45} -> next cycle rollback_valid = 1 and map_out[3] = 45; free[0] = 3.
- Async reset asserted mid-cycle right after a retire -> outputs return to reset values before the next clock edge; retire_count = 0.

Source files
------------

// File: rtl/rrat_pkg.sv
// rrat_pkg
//   Shared types and constants for the retirement register alias table.
//   NUM_ARCH / NUM_PREG    : architectural and physical register counts
//                            (NUM_PREG must be at least NUM_ARCH)
//   ARCH_IDX_WIDTH         : architectural index width
//   PREG_IDX_WIDTH         : physical tag width
//   RRAT_RETIRE_INPACKET   : one retire way {valid, arch, preg}
//   RRAT_FREE_OUTPACKET    : one released tag {valid, preg}
//   rrat_map_t             : whole committed map, entry i = physical tag of arch i
package rrat_pkg;

    localparam int NUM_ARCH       = 32;
    localparam int NUM_PREG       = 64;
    localparam int ARCH_IDX_WIDTH = $clog2(NUM_ARCH);
    localparam int PREG_IDX_WIDTH = $clog2(NUM_PREG);

    typedef struct packed {
        logic                      valid;
        logic [ARCH_IDX_WIDTH-1:0] arch;
        logic [PREG_IDX_WIDTH-1:0] preg;
    } RRAT_RETIRE_INPACKET;

    typedef struct packed {
        logic                      valid;
        logic [PREG_IDX_WIDTH-1:0] preg;
    } RRAT_FREE_OUTPACKET;

    typedef logic [NUM_ARCH-1:0][PREG_IDX_WIDTH-1:0] rrat_map_t;

    // Reset image: architectural register i lives in physical register i.
    function automatic rrat_map_t rrat_identity_map();
        rrat_map_t m;
        for (int i = 0; i < NUM_ARCH; i++) begin
            m[i] = PREG_IDX_WIDTH'(i);
        end
        return m;
    endfunction

endpackage

// File: rtl/rrat_retire_slice.sv
// rrat_retire_slice
//   Combinational update of the map by a single retire way.
//   map_in    : working map including all older ways of this cycle
//   retire_in : this way's retirement {valid, arch, preg}
//   map_out   : working map after this way
//   free_out  : tag displaced by this way (valid only when the way is accepted)
module rrat_retire_slice
    import rrat_pkg::*;
(
    input  rrat_map_t           map_in,
    input  RRAT_RETIRE_INPACKET retire_in,
    output rrat_map_t           map_out,
    output RRAT_FREE_OUTPACKET  free_out
);

    always_comb begin
        map_out  = map_in;
        free_out = '0;
        // Arch 0 is hard-wired: such a write is dropped entirely.
        if (retire_in.valid && (retire_in.arch != '0)) begin
            free_out.valid          = 1'b1;
            free_out.preg           = map_in[retire_in.arch];
            map_out[retire_in.arch] = retire_in.preg;
        end
    end

endmodule

// File: rtl/rrat_retire_map.sv
// rrat_retire_map
//   Retirement register alias table: committed arch->phys map updated by up to
//   SCALAR in-order retirements per cycle (youngest way wins on conflicts).
//   clock          : rising-edge clock
//   reset          : asynchronous, active-high
//   retire_packet  : SCALAR retire ways, way 0 oldest
//   rollback_en    : rollback request (level)
//   map_out        : committed map (registered)
//   free_packet    : displaced tags, one cycle after retirement (registered)
//   rollback_valid : map_out is the restore image this cycle
//   retire_count   : running count of accepted retirements (wraps)
module rrat_retire_map
    import rrat_pkg::*;
#(
    parameter int SCALAR      = 2,
    parameter int COUNT_WIDTH = 32
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  RRAT_RETIRE_INPACKET [SCALAR-1:0]     retire_packet,
    input  logic                                 rollback_en,
    output rrat_map_t                            map_out,
    output RRAT_FREE_OUTPACKET  [SCALAR-1:0]     free_packet,
    output logic                                 rollback_valid,
    output logic [COUNT_WIDTH-1:0]               retire_count
);

    rrat_map_t              work_p0 [SCALAR+1];
    RRAT_FREE_OUTPACKET     free_p0 [SCALAR];
    logic [COUNT_WIDTH-1:0] accepted_p0;

    // Stage p0: chained per-way updates starting from the committed map.
    assign work_p0[0] = map_out;

    for (genvar k = 0; k < SCALAR; k++) begin : g_way
        rrat_retire_slice u_slice (
            .map_in    (work_p0[k]),
            .retire_in (retire_packet[k]),
            .map_out   (work_p0[k+1]),
            .free_out  (free_p0[k])
        );
    end

    always_comb begin
        accepted_p0 = '0;
        for (int k = 0; k < SCALAR; k++) begin
            accepted_p0 = accepted_p0 + COUNT_WIDTH'(free_p0[k].valid);
        end
    end

    // Stage p1: committed state; rollback simply flags the post-retire map.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            map_out        <= rrat_identity_map();
            free_packet    <= '0;
            rollback_valid <= 1'b0;
            retire_count   <= '0;
        end else begin
            map_out        <= work_p0[SCALAR];
            for (int k = 0; k < SCALAR; k++) begin
                free_packet[k] <= free_p0[k];
            end
            rollback_valid <= rollback_en;
            retire_count   <= retire_count + accepted_p0;
        end
    end

endmodule

// File: tb/tb_rrat_retire_map.sv
module tb_rrat_retire_map;
    import rrat_pkg::*;

    localparam int SCALAR      = 2;
    localparam int COUNT_WIDTH = 32;

    typedef struct {
        rrat_map_t                       map;
        RRAT_FREE_OUTPACKET [SCALAR-1:0] free;
        logic [COUNT_WIDTH-1:0]          cnt;
        logic                            rbv;
    } exp_t;

    typedef RRAT_RETIRE_INPACKET [SCALAR-1:0] pkt_t;

    logic                            clock;
    logic                            reset;
    pkt_t                            retire_packet;
    logic                            rollback_en;
    rrat_map_t                       map_out;
    RRAT_FREE_OUTPACKET [SCALAR-1:0] free_packet;
    logic                            rollback_valid;
    logic [COUNT_WIDTH-1:0]          retire_count;

    rrat_retire_map #(.SCALAR(SCALAR), .COUNT_WIDTH(COUNT_WIDTH)) dut (
        .clock          (clock),
        .reset          (reset),
        .retire_packet  (retire_packet),
        .rollback_en    (rollback_en),
        .map_out        (map_out),
        .free_packet    (free_packet),
        .rollback_valid (rollback_valid),
        .retire_count   (retire_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_pass = 0;

    exp_t       sb [$];
    rrat_map_t  m_map;
    logic [COUNT_WIDTH-1:0] m_cnt;
    logic [PREG_IDX_WIDTH-1:0] free_list [$];

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic compare_front();
        exp_t e;
        e = sb.pop_front();
        check("map", 256'(map_out), 256'(e.map));
        for (int k = 0; k < SCALAR; k++) begin
            check($sformatf("free%0d", k), 256'(free_packet[k]), 256'(e.free[k]));
        end
        check("count", 256'(retire_count), 256'(e.cnt));
        check("rollback_valid", 256'(rollback_valid), 256'(e.rbv));
    endtask

    function automatic exp_t reset_image();
        exp_t e;
        e.map  = rrat_identity_map();
        e.free = '0;
        e.cnt  = '0;
        e.rbv  = 1'b0;
        return e;
    endfunction

    // Apply one cycle of stimulus, predict, then compare just after the edge.
    task automatic drive_cycle(input pkt_t pk, input logic rb, output exp_t e);
        int n;
        bit mapped;
        retire_packet = pk;
        rollback_en   = rb;
        e.map  = m_map;
        e.free = '0;
        n = 0;
        for (int k = 0; k < SCALAR; k++) begin
            if (pk[k].valid && pk[k].arch != 0) begin
                mapped = 0;
                for (int i = 0; i < NUM_ARCH; i++) if (e.map[i] == pk[k].preg) mapped = 1;
                assert (!mapped) else $error("illegal retire: preg %0d already mapped", pk[k].preg);
                e.free[k].valid = 1'b1;
                e.free[k].preg  = e.map[pk[k].arch];
                e.map[pk[k].arch] = pk[k].preg;
                n++;
            end
        end
        e.cnt = m_cnt + COUNT_WIDTH'(n);
        e.rbv = rb;
        sb.push_back(e);
        @(posedge clock);
        #1;
        compare_front();
        retire_packet = '0;
        rollback_en   = 1'b0;
        m_map = e.map;
        m_cnt = e.cnt;
    endtask

    function automatic pkt_t mk2(input logic v0, input int a0, input int p0,
                                 input logic v1, input int a1, input int p1);
        pkt_t p;
        p[0].valid = v0; p[0].arch = ARCH_IDX_WIDTH'(a0); p[0].preg = PREG_IDX_WIDTH'(p0);
        p[1].valid = v1; p[1].arch = ARCH_IDX_WIDTH'(a1); p[1].preg = PREG_IDX_WIDTH'(p1);
        return p;
    endfunction

    initial begin
        exp_t e;
        pkt_t pk;
        retire_packet = '0;
        rollback_en   = 1'b0;
        reset         = 1'b1;
        m_map = rrat_identity_map();
        m_cnt = '0;
        repeat (2) @(posedge clock);
        #3 reset = 1'b0;
        #1;
        sb.push_back(reset_image());
        compare_front();

        // Two independent retirements.
        drive_cycle(mk2(1, 1, 40, 1, 2, 41), 1'b0, e);
        check("map1_dir", 256'(map_out[1]), 256'(40));
        check("map2_dir", 256'(map_out[2]), 256'(41));
        // Same-arch conflict: younger way frees older way's tag.
        drive_cycle(mk2(1, 5, 50, 1, 5, 51), 1'b0, e);
        check("map5_dir", 256'(map_out[5]), 256'(51));
        check("free1_dir", 256'(free_packet[1].preg), 256'(50));
        // Arch 0 write is ignored.
        drive_cycle(mk2(1, 0, 60, 0, 0, 0), 1'b0, e);
        check("map0_dir", 256'(map_out[0]), 256'(0));
        check("count_dir", 256'(retire_count), 256'(4));
        // Retire and rollback together.
        drive_cycle(mk2(1, 3, 45, 0, 0, 0), 1'b1, e);
        check("map3_rb", 256'(map_out[3]), 256'(45));
        // Rollback held three cycles, then released.
        for (int i = 0; i < 4; i++) drive_cycle('0, (i < 3), e);

        // Async reset between edges right after a retire.
        drive_cycle(mk2(1, 7, 46, 1, 8, 47), 1'b0, e);
        #1 reset = 1'b1;
        #1;
        sb.push_back(reset_image());
        compare_front();
        #2 reset = 1'b0;
        m_map = rrat_identity_map();
        m_cnt = '0;

        // Random legal traffic drawn from a free-list model.
        for (int p = NUM_ARCH; p < NUM_PREG; p++) free_list.push_back(PREG_IDX_WIDTH'(p));
        for (int c = 0; c < 200; c++) begin
            for (int k = 0; k < SCALAR; k++) begin
                pk[k].valid = ($urandom_range(0, 3) != 0);
                pk[k].arch  = ARCH_IDX_WIDTH'($urandom_range(0, NUM_ARCH - 1));
                if (c % 17 == 0) pk[k].arch = ARCH_IDX_WIDTH'(9);
                if (pk[k].valid && pk[k].arch != 0) pk[k].preg = free_list.pop_front();
                else pk[k].preg = PREG_IDX_WIDTH'($urandom_range(0, NUM_PREG - 1));
            end
            drive_cycle(pk, ($urandom_range(0, 3) == 0), e);
            for (int k = 0; k < SCALAR; k++) if (e.free[k].valid) free_list.push_back(e.free[k].preg);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
